// File: rtl/parca_uretici.sv
// parca_uretici: paced piece source for tetris; pieces come from an 8-bit LFSR,
// or from SABIT_PARCA when PARCA_SABIT_EN is defined. Stops on game over or height limit.
module parca_uretici #(
  parameter int         BOSLUK          = 1,
  parameter logic [7:0] TOHUM           = 8'hA5,
  parameter int         YUKSEKLIK_LIMIT = 20,
  parameter logic [2:0] SABIT_PARCA     = 3'b101
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       basla,
  input  logic [4:0] yukseklik,
  input  logic [4:0] cevrim,
  input  logic       bitti_mi,
  output logic [2:0] parca,
  output logic [7:0] parca_sayisi,
  output logic       oyun_bitti,
  output logic [4:0] son_cevrim
);
  typedef enum logic [1:0] {BEKLE, GONDER, ARA, BITTI} durum_t;
  localparam int CW = $clog2(BOSLUK + 2);
  durum_t         durum_q, durum_d;
  logic [CW-1:0]  bos_q, bos_d;
  logic [2:0]     parca_q, parca_d, kod;
  logic [7:0]     sayi_q, sayi_d;
  logic           bitti_q, bitti_d, dur;
  logic [4:0]     son_q, son_d;
  assign dur = bitti_mi || (yukseklik >= 5'(YUKSEKLIK_LIMIT));
`ifdef PARCA_SABIT_EN
  assign kod = SABIT_PARCA;
`else
  localparam logic [7:0] SEED = (TOHUM == 8'h00) ? 8'h01 : TOHUM;
  logic [7:0] lfsr_q, lfsr_d;
  assign kod = (lfsr_q[2:0] == 3'b000) ? 3'b001 : lfsr_q[2:0];
  always_comb
    lfsr_d = (durum_q == BITTI && basla) ? SEED :
             (durum_q == GONDER && !dur) ? {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]} :
             lfsr_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) lfsr_q <= SEED;
    else     lfsr_q <= lfsr_d;
`endif
  always_comb begin
    durum_d = durum_q;
    bos_d   = bos_q;
    parca_d = 3'b000;
    sayi_d  = sayi_q;
    bitti_d = bitti_q;
    son_d   = son_q;
    case (durum_q)
      BEKLE: if (basla) durum_d = GONDER;
      GONDER, ARA:
        // stopping wins over issuing, so a stopped GONDER emits a bubble
        if (dur) begin
          durum_d = BITTI;
          bitti_d = 1'b1;
          son_d   = cevrim;
        end else if (durum_q == GONDER) begin
          parca_d = kod;
          sayi_d  = sayi_q + {7'd0, sayi_q != 8'hFF};
          bos_d   = CW'(1);
          durum_d = (BOSLUK > 0) ? ARA : GONDER;
        end else if (bos_q == CW'(BOSLUK)) durum_d = GONDER;
        else bos_d = bos_q + 1'b1;
      BITTI:
        if (basla) begin
          durum_d = BEKLE;
          sayi_d  = 8'd0;
          bitti_d = 1'b0;
        end
      default: durum_d = BEKLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      durum_q <= BEKLE;
      bos_q   <= '0;
      parca_q <= 3'b000;
      sayi_q  <= 8'd0;
      bitti_q <= 1'b0;
      son_q   <= 5'd0;
    end else begin
      durum_q <= durum_d;
      bos_q   <= bos_d;
      parca_q <= parca_d;
      sayi_q  <= sayi_d;
      bitti_q <= bitti_d;
      son_q   <= son_d;
    end
  assign parca        = parca_q;
  assign parca_sayisi = sayi_q;
  assign oyun_bitti   = bitti_q;
  assign son_cevrim   = son_q;
endmodule

// File: tb/tb_parca_uretici.sv
// tb_parca_uretici: scoreboard bench; expected pieces are queued at stimulus time, a monitor pops them.
module tb_parca_uretici;
  localparam int BOSLUK = 1;
  logic       clk = 1'b0, rst = 1'b1, basla = 1'b0, bitti_mi = 1'b0;
  logic [4:0] yukseklik = 5'd0, cevrim = 5'd0;
  logic [2:0] parca;
  logic [7:0] parca_sayisi;
  logic       oyun_bitti;
  logic [4:0] son_cevrim;
  always #5 clk = ~clk;
  parca_uretici #(.BOSLUK(BOSLUK), .TOHUM(8'hA5), .YUKSEKLIK_LIMIT(20)) dut (
    .clk(clk), .rst(rst), .basla(basla), .yukseklik(yukseklik), .cevrim(cevrim),
    .bitti_mi(bitti_mi), .parca(parca), .parca_sayisi(parca_sayisi),
    .oyun_bitti(oyun_bitti), .son_cevrim(son_cevrim)
  );
  int passed = 0, total = 0, seen = 0;
  logic [2:0] exp_q[$];
  logic [7:0] m_lfsr = 8'hA5;
  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask
  task automatic push(input int k);
    for (int i = 0; i < k; i++) begin
      exp_q.push_back(m_lfsr[2:0] == 3'b000 ? 3'b001 : m_lfsr[2:0]);
      m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end
  endtask
  task automatic step;
    @(negedge clk);
    #1;
  endtask
  initial begin
    int  gap = 0;
    bit  have = 0;
    forever begin
      @(negedge clk);
      if (rst || oyun_bitti) begin
        have = 0;
        gap  = 0;
      end else begin
        gap++;
        if (parca != 3'b000) begin
          if (exp_q.size() == 0) chk("extra_piece", int'(parca), 0);
          else chk("piece", int'(parca), int'(exp_q.pop_front()));
          if (have) chk("period", gap, BOSLUK + 1);
          have = 1;
          gap  = 0;
          seen++;
        end
      end
    end
  end
  task automatic wait_seen(input int target, input int budget);
    int b = budget;
    while (seen < target && b > 0) begin
      step;
      b--;
    end
    chk("pieces_seen", seen, target);
  endtask
  // kind[0]: stop by height (else bitti_mi); kind[1]: stop in the cycle before GONDER's piece
  task automatic do_run(input int k, input int kind, input logic [4:0] cv, input logic [4:0] ht);
    int target = seen + k;
    int cnt = (k > 255) ? 255 : k;
    yukseklik = ht;
    bitti_mi  = 1'b0;
    push(k);
    basla = 1'b1;
    step;
    basla = 1'b0;
    chk("latency_idle", int'(parca), 0);
    step;
    chk("latency_piece", int'(parca != 3'b000), 1);
    wait_seen(target, 4 * k + 20);
    if (kind >= 2) step;
    cevrim = cv;
    if (kind % 2 == 1) yukseklik = 5'(20 + $urandom_range(0, 11));
    else bitti_mi = 1'b1;
    step;
    chk("stop_flag", int'(oyun_bitti), 1);
    chk("stop_parca", int'(parca), 0);
    chk("stop_son", int'(son_cevrim), int'(cv));
    chk("stop_count", int'(parca_sayisi), cnt);
    bitti_mi  = 1'b0;
    yukseklik = 5'd0;
    cevrim    = ~cv;
    repeat (4) step;
    chk("hold_son", int'(son_cevrim), int'(cv));
    chk("hold_flag", int'(oyun_bitti), 1);
    chk("hold_count", int'(parca_sayisi), cnt);
  endtask
  task automatic restart;
    basla = 1'b1;
    step;
    basla = 1'b0;
    chk("restart_flag", int'(oyun_bitti), 0);
    chk("restart_count", int'(parca_sayisi), 0);
    m_lfsr = 8'hA5;
    step;
    chk("restart_idle", int'(parca), 0);
  endtask
  initial begin
    int target;
    repeat (2) step;
    chk("rst_parca", int'(parca), 0);
    chk("rst_count", int'(parca_sayisi), 0);
    chk("rst_flag", int'(oyun_bitti), 0);
    chk("rst_son", int'(son_cevrim), 0);
    rst = 1'b0;
    repeat (3) step;
    chk("idle_parca", int'(parca), 0);
    chk("idle_count", int'(parca_sayisi), 0);
    do_run(3, 0, 5'd17, 5'd0);
    restart;
    do_run(4, 3, 5'd9, 5'd19);
    for (int r = 0; r < 6; r++) begin
      restart;
      do_run(int'($urandom_range(1, 12)), int'($urandom_range(0, 3)), 5'($urandom), 5'($urandom_range(0, 19)));
    end
    restart;
    do_run(260, 1, 5'd30, 5'd0);
    restart;
    push(10);
    target = seen + 3;
    basla = 1'b1;
    step;
    basla = 1'b0;
    wait_seen(target, 30);
    #1 rst = 1'b1;
    #1;
    chk("async_parca", int'(parca), 0);
    chk("async_count", int'(parca_sayisi), 0);
    chk("async_flag", int'(oyun_bitti), 0);
    exp_q.delete();
    m_lfsr = 8'hA5;
    repeat (2) step;
    rst = 1'b0;
    repeat (5) step;
    chk("post_rst_count", int'(parca_sayisi), 0);
    chk("post_rst_parca", int'(parca), 0);
    do_run(3, 2, 5'd11, 5'd19);
    chk("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/parca_uretici.md
# parca_uretici

Piece source for the `tetris` core: drives its `parca` input with a paced stream of piece codes, separated by idle `000` slots.
- Pieces come from an 8-bit LFSR, or are a fixed code when so configured.
- Watches the core's `yukseklik` and `bitti_mi` and stops issuing pieces once the game ends.
- Sits directly upstream of `tetris`, replacing hand-written stimulus in system-level runs.

## Interface
Parameters:
- `BOSLUK`, 1, number of idle (`000`) cycles inserted after each piece; 0 gives back-to-back pieces.
- `TOHUM`, 8'hA5, LFSR seed. A value of 0 is replaced by 8'h01.
- `YUKSEKLIK_LIMIT`, 20, stack height at or above which generation stops.
- `SABIT_PARCA`, 3'b101, piece code emitted when `PARCA_SABIT_EN` is defined.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `basla` input 1: start or restart request, sampled on `clk`.
- `yukseklik` input 5: current stack height from `tetris`.
- `cevrim` input 5: cycle count from `tetris`; passed through unchanged on `son_cevrim`.
- `bitti_mi` input 1: game-over flag from `tetris`.
- `parca` output 3: piece code to `tetris`; 000 means no piece.
- `parca_sayisi` output 8: number of pieces issued, saturates at 255.
- `oyun_bitti` output 1: generator has stopped.
- `son_cevrim` output 5: `cevrim` value latched when the generator stopped.

## Operation
States:
- BEKLE:
  - `parca`=000.
  - `basla`=1 → GONDER.
- GONDER (exactly 1 cycle):
  - `parca` = current piece code.
  - `parca_sayisi`++ (saturating).
  - LFSR advances.
  - Then ARA if `BOSLUK`>0, otherwise GONDER again.
- ARA:
  - `parca`=000.
  - Idle counter runs 1..`BOSLUK`, then → GONDER.
- BITTI:
  - `parca`=000, `oyun_bitti`=1.
  - `basla`=1 → BEKLE, with LFSR reloaded from `TOHUM`, `parca_sayisi`=0, `oyun_bitti`=0.

Stop condition:
- Condition is `bitti_mi`=1 OR `yukseklik` ≥ `YUKSEKLIK_LIMIT` (unsigned 5-bit compare).
- Evaluated every cycle in GONDER and ARA.
- When true: → BITTI and capture `son_cevrim` ← `cevrim`.
- The stop condition has priority over issuing a piece. A cycle that would have been GONDER emits 000 instead and does not increment the count.
- `basla` is ignored in GONDER and ARA.

LFSR:
- Update: `lfsr` ← {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
- Piece code = lfsr[2:0], except 000 is mapped to 001. The bubble code therefore never appears as a piece.

## Timing
- All outputs are registered.
- Reset values: `parca`=000, `parca_sayisi`=0, `oyun_bitti`=0, `son_cevrim`=0, state BEKLE, `lfsr`=`TOHUM`.
- `basla` sampled high at edge N → first piece on `parca` after edge N+1 (1-cycle latency).
- Piece period is 1+`BOSLUK` cycles. With `BOSLUK`=1: 101,000,101,000…
- Stop condition present before edge M → from edge M: `parca`=000 and `oyun_bitti`=1. No further piece is emitted after the stop is observed.
- `rst` asserted mid-operation forces the reset values immediately, without waiting for a clock edge. On release the block waits in BEKLE for `basla`.
- Count saturation: at 255 the count holds. Pieces continue to be issued.

## Configuration
`PARCA_SABIT_EN`:
- Defined: every GONDER emits `SABIT_PARCA`. The LFSR is not instantiated and the count still increments.
- Undefined: pieces come from the LFSR as described above.

## Test plan
- **Reset:** assert `rst` mid-ARA → `parca`=000, `parca_sayisi`=0, `oyun_bitti`=0 before the next edge. After release, no pieces are issued until `basla`.
- **Fixed mode:** `PARCA_SABIT_EN`, `BOSLUK`=1, `basla` pulse, `bitti_mi`=0, `yukseklik`=0 → `parca` = 101,000,101,000…; `parca_sayisi`=4 after 8 cycles.
- **LFSR sequence:** default build, `TOHUM`=8'hA5, `BOSLUK`=0 → pieces 5,2,5 on 3 consecutive cycles (LFSR A5→4A→95).
- **Game over:** `bitti_mi`=1 during ARA with `cevrim`=17 → next edge `oyun_bitti`=1, `son_cevrim`=17. `parca` stays 000 for all later cycles.
- **Height limit:** `yukseklik`=20 arriving in the cycle before a GONDER → no piece is emitted, the count is unchanged and `oyun_bitti`=1. `yukseklik`=19 does not stop the generator.
- **Restart:** `basla` in BITTI → BEKLE with count 0. The next `basla` reproduces the 5,2,5 sequence.
